uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter HEADER, default 8'hAA, packet start byte.
REQ-002 Parameter TIMEOUT, default 50000, maximum idle clk cycles allowed between bytes inside a packet.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 rx_error  input  1  one-cycle strobe; framing error on the current byte.
REQ-008 freq_out  output  8  frequency setting, to the clock divider and display.
REQ-009 amp_out  output  4  amplitude setting.
REQ-010 wave_sel  output  2  waveform select: 00 square, 01 sine, 10 triangle, 11 reserved.
REQ-011 cfg_valid  output  1  one-cycle pulse; new settings were applied.
REQ-012 cfg_err  output  1  one-cycle pulse; packet was rejected.
REQ-013 busy  output  1  high while a packet is in progress (state not IDLE).

Function
REQ-014 Packet format SHALL be four bytes: HEADER, CMD, FREQ, CHK.
  - CMD[1:0] = wave, CMD[5:2] = amp, CMD[7:6] = reserved and must be 00.
  - CHK = (CMD + FREQ) mod 256.
REQ-015 FSM states SHALL be IDLE, GET_CMD, GET_FREQ, GET_CHK.
  - A byte is accepted on a clk edge where rx_valid=1 and rx_error=0.
REQ-016 IDLE: an accepted byte equal to HEADER → GET_CMD; any other byte is ignored with no cfg_err; rx_error is ignored.
REQ-017 GET_CMD → GET_FREQ → GET_CHK, one accepted byte each, with the byte latched.
  - A HEADER value received in these states is treated as data; there is no resync.
REQ-018 GET_CHK, on an accepted byte, SHALL go to IDLE and register the verdict.
  - Valid = CHK matches, CMD[7:6]==00, CMD[1:0]!=11, and FREQ!=0.
REQ-019 Valid packet: freq_out, amp_out and wave_sel update, and cfg_valid pulses, both on the clk edge after the CHK byte is sampled (latency 1 cycle).
REQ-020 Invalid packet: cfg_err pulses 1 cycle after the CHK byte; outputs hold their previous values.
REQ-021 rx_error=1 in any non-IDLE state SHALL abort to IDLE with a cfg_err pulse next cycle.
  - rx_error wins over a simultaneous rx_valid; that byte is discarded.
REQ-022 Timeout counter:
  - Cleared on entry to GET_CMD and on every accepted byte; counts in non-IDLE states.
  - On reaching TIMEOUT-1 with no byte: abort to IDLE, cfg_err pulse.
  - An accepted byte in that same cycle wins (no timeout).
  - Width = clog2(TIMEOUT).
REQ-023 cfg_valid and cfg_err SHALL never be high in the same cycle, and neither SHALL be high for more than 1 cycle.
REQ-024 busy SHALL be combinational from the state register: 1 in GET_CMD, GET_FREQ and GET_CHK.

Reset
REQ-025 rst=1 SHALL force: state IDLE, timeout counter 0, freq_out 8'd10, amp_out 4'd8, wave_sel 2'b01, cfg_valid 0, cfg_err 0.
REQ-026 rst SHALL dominate every other input.
  - Reset mid-packet discards the partial packet with no cfg_err pulse.
  - Settings return to their reset values.

Verification
REQ-027 Good packet: AA 09 32 3B → one cfg_valid pulse 1 cycle after 3B; freq_out=0x32, amp_out=2, wave_sel=01; cfg_err stays 0.
REQ-028 Bad checksum: AA 09 32 00 → one cfg_err pulse; freq_out/amp_out/wave_sel unchanged (reset values 10/8/01).
REQ-029 Reserved bits set: AA C1 10 D1 → cfg_err.
  - Then AA 06 14 1A → cfg_valid; freq_out=0x14, amp_out=1, wave_sel=10.
REQ-030 Noise plus timeout:
  - 55 alone → ignored; busy stays 0.
  - AA 09 then no bytes for TIMEOUT cycles (TIMEOUT=16 in the bench) → cfg_err exactly at the timeout cycle, busy drops.
  - The next good packet is accepted.
REQ-031 Abort cases:
  - rx_error during GET_FREQ → cfg_err and IDLE.
  - rst asserted after AA 09 → no pulse, outputs at reset values.
  - Completing the remaining bytes 32 3B without a new header → no cfg_valid.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 4-byte command packets (HEADER, CMD, FREQ, CHK)
// from a UART receiver byte stream and applies validated settings.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   rx_data        - received byte
//   rx_valid       - one-cycle strobe, rx_data valid
//   rx_error       - one-cycle strobe, framing error on current byte
//   freq_out       - frequency setting
//   amp_out        - amplitude setting
//   wave_sel       - waveform select (00 square, 01 sine, 10 triangle)
//   cfg_valid      - one-cycle pulse, new settings applied
//   cfg_err        - one-cycle pulse, packet rejected
//   busy           - packet in progress (combinational from state)
module uart_cmd_parser #(
  parameter logic [7:0]  HEADER  = 8'hAA,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [7:0] freq_out,
  output logic [3:0] amp_out,
  output logic [1:0] wave_sel,
  output logic       cfg_valid,
  output logic       cfg_err,
  output logic       busy
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_CMD  = 2'd1,
    GET_FREQ = 2'd2,
    GET_CHK  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_cmd;
  logic [7:0]       r_freq;

  logic w_accept;
  logic w_pkt_ok;
  logic w_timeout;

  assign w_accept  = rx_valid & ~rx_error;
  assign w_timeout = (r_cnt == CNT_LAST);

  // Verdict on the CHK byte currently on rx_data
  assign w_pkt_ok = (rx_data == 8'(r_cmd + r_freq)) &&
                    (r_cmd[7:6] == 2'b00) &&
                    (r_cmd[1:0] != 2'b11) &&
                    (r_freq != 8'd0);

  assign busy = (r_state != IDLE);

  // Packet FSM, idle timer and registered settings/pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cmd     <= 8'd0;
      r_freq    <= 8'd0;
      freq_out  <= 8'd10;
      amp_out   <= 4'd8;
      wave_sel  <= 2'b01;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
      if (r_state == IDLE) begin
        // Entry clear of the idle timer happens here; noise bytes are dropped silently
        r_cnt <= '0;
        if (w_accept && (rx_data == HEADER)) begin
          r_state <= GET_CMD;
        end
      end else begin
        // Priority: framing error, then accepted byte, then timeout
        if (rx_error) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          cfg_err <= 1'b1;
        end else if (rx_valid) begin
          r_cnt <= '0;
          case (r_state)
            GET_CMD: begin
              r_cmd   <= rx_data;
              r_state <= GET_FREQ;
            end
            GET_FREQ: begin
              r_freq  <= rx_data;
              r_state <= GET_CHK;
            end
            default: begin
              r_state <= IDLE;
              if (w_pkt_ok) begin
                freq_out  <= r_freq;
                amp_out   <= r_cmd[5:2];
                wave_sel  <= r_cmd[1:0];
                cfg_valid <= 1'b1;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          endcase
        end else if (w_timeout) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          cfg_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed bench for uart_cmd_parser with a result
// scoreboard; expected verdicts are queued as CHK/abort stimulus is driven
// and popped whenever the DUT pulses cfg_valid or cfg_err.
module tb_uart_cmd_parser;

  localparam logic [7:0]  HDR = 8'hAA;
  localparam int unsigned TO  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic [7:0] freq_out;
  logic [3:0] amp_out;
  logic [1:0] wave_sel;
  logic       cfg_valid;
  logic       cfg_err;
  logic       busy;

  typedef struct packed {
    logic       ok;
    logic [7:0] f;
    logic [3:0] a;
    logic [1:0] w;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_f;
  logic [3:0] m_a;
  logic [1:0] m_w;

  uart_cmd_parser #(.HEADER(HDR), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .freq_out (freq_out),
    .amp_out  (amp_out),
    .wave_sel (wave_sel),
    .cfg_valid(cfg_valid),
    .cfg_err  (cfg_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample after the edge, and score any result pulse
  task automatic tick();
    exp_t e;
    exp_t o;
    @(posedge clk);
    #1;
    if (cfg_valid === 1'b1 || cfg_err === 1'b1) begin
      check("pulse_exclusive", {31'd0, cfg_valid & cfg_err}, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'd0, cfg_valid, cfg_err}, 32'd0);
      end else begin
        e = q.pop_front();
        o = {cfg_valid, freq_out, amp_out, wave_sel};
        check("sb_result", 32'(o), 32'(e));
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic model_reset();
    m_f = 8'd10;
    m_a = 4'd8;
    m_w = 2'b01;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic push_err();
    q.push_back({1'b0, m_f, m_a, m_w});
  endtask

  // Full packet; the verdict is computed from the packet rules and queued
  task automatic send_packet(input logic [7:0] c, input logic [7:0] f, input logic [7:0] k);
    logic ok;
    send(HDR);
    send(c);
    send(f);
    ok = (k == 8'(c + f)) && (c[7:6] == 2'b00) && (c[1:0] != 2'b11) && (f != 8'd0);
    if (ok) begin
      m_f = f;
      m_a = c[5:2];
      m_w = c[1:0];
    end
    q.push_back({ok, m_f, m_a, m_w});
    send(k);
    check("drain", 32'(q.size()), 32'd0);
    check("busy_after_pkt", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outs();
    check("freq_rst", {24'd0, freq_out}, 32'h0A);
    check("amp_rst",  {28'd0, amp_out},  32'd8);
    check("wave_rst", {30'd0, wave_sel}, 32'd1);
    check("busy_rst", {31'd0, busy},     32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check_reset_outs();
    check("cfg_valid_rst", {31'd0, cfg_valid}, 32'd0);
    check("cfg_err_rst",   {31'd0, cfg_err},   32'd0);

    // Good packet
    send_packet(8'h09, 8'h32, 8'h3B);
    check("good_freq", {24'd0, freq_out}, 32'h32);
    check("good_amp",  {28'd0, amp_out},  32'd2);
    check("good_wave", {30'd0, wave_sel}, 32'd1);

    // Bad checksum from reset settings
    do_reset();
    send_packet(8'h09, 8'h32, 8'h00);
    check_reset_outs();

    // Reserved bits set, then a valid packet
    send_packet(8'hC1, 8'h10, 8'hD1);
    send_packet(8'h06, 8'h14, 8'h1A);
    check("p2_freq", {24'd0, freq_out}, 32'h14);
    check("p2_amp",  {28'd0, amp_out},  32'd1);
    check("p2_wave", {30'd0, wave_sel}, 32'd2);

    // FREQ zero, reserved wave, header value carried as data
    send_packet(8'h00, 8'h00, 8'h00);
    send_packet(8'h03, 8'h05, 8'h08);
    send_packet(8'h01, 8'hAA, 8'hAB);
    check("hdr_data_freq", {24'd0, freq_out}, 32'hAA);

    // Noise in IDLE
    send(8'h55);
    check("noise_busy", {31'd0, busy}, 32'd0);
    tick();
    check("noise_busy2", {31'd0, busy}, 32'd0);

    // rx_error in IDLE is ignored
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    check("idle_err_busy", {31'd0, busy}, 32'd0);

    // Timeout: abort exactly TO cycles after the last accepted byte
    send(HDR);
    send(8'h09);
    for (int i = 1; i < int'(TO); i++) begin
      tick();
      check("to_early_err", {31'd0, cfg_err}, 32'd0);
      check("to_early_busy", {31'd0, busy}, 32'd1);
    end
    push_err();
    tick();
    check("to_err", {31'd0, cfg_err}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_drain", 32'(q.size()), 32'd0);
    send_packet(8'h09, 8'h32, 8'h3B);
    check("after_to_freq", {24'd0, freq_out}, 32'h32);

    // rx_error during GET_FREQ wins over a simultaneous valid byte
    send(HDR);
    send(8'h05);
    push_err();
    rx_data  = 8'h32;
    rx_valid = 1'b1;
    rx_error = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_error = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_drain", 32'(q.size()), 32'd0);
    check("abort_freq", {24'd0, freq_out}, 32'h32);

    // Reset mid-packet, then the tail alone must not complete a packet
    send(HDR);
    send(8'h09);
    check("mid_busy", {31'd0, busy}, 32'd1);
    do_reset();
    check("mid_rst_err", {31'd0, cfg_err}, 32'd0);
    check_reset_outs();
    send(8'h32);
    send(8'h3B);
    tick();
    check_reset_outs();
    check("tail_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
